// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer: walks the register table from index 0 and issues
// each entry as one SCCB transaction, with power-up/soft-reset delays, NACK retries and read capture.
module ov7670_config_seq #(
    parameter logic [23:0] PWRUP_CYCLES      = 24'd1_000_000,
    parameter logic [23:0] RESET_WAIT_CYCLES = 24'd1_000_000,
    parameter logic [15:0] GAP_CYCLES        = 16'd100,
    parameter int unsigned MAX_RETRIES       = 3,
    parameter logic [6:0]  LAST_INDEX        = 7'd127
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [6:0]  index_o,
    input  logic [16:0] data_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  cmd_addr_o,
    output logic [7:0]  cmd_data_o,
    output logic        cmd_rw_o,
    input  logic        cmd_done_i,
    input  logic        cmd_nack_i,
    input  logic [7:0]  cmd_rdata_i,
    output logic        rd_valid_o,
    output logic [7:0]  rd_addr_o,
    output logic [7:0]  rd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [6:0]  err_index_o
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // A programmed delay of zero still spends one cycle in the counting state.
    localparam logic [23:0] PWRUP_LOAD  = (PWRUP_CYCLES == '0) ? 24'd1 : PWRUP_CYCLES;
    localparam logic [23:0] SETTLE_LOAD = (RESET_WAIT_CYCLES == '0) ? 24'd1 : RESET_WAIT_CYCLES;
    localparam logic [23:0] GAP_LOAD    = (GAP_CYCLES == '0) ? 24'd1 : {8'd0, GAP_CYCLES};
    localparam logic [7:0]  MAX_RETRY_CNT = 8'(MAX_RETRIES);

    state_t      state, state_next;
    logic [23:0] delay_cnt;
    logic [7:0]  retry_cnt;
    logic        retrying;

    logic [23:0] delay_load;
    logic        delay_set;
    logic        start_acc;
    logic        fetch_en;
    logic        retry_inc;
    logic        ack_done;
    logic        abort;
    logic        index_inc;
    logic        finish;

    logic delay_expired;
    logic is_terminator;
    logic is_soft_reset;

    assign delay_expired = (delay_cnt <= 24'd1);
    assign is_terminator = (data_i[16:1] == 16'hffff);
    assign is_soft_reset = cmd_rw_o && (cmd_addr_o == 8'h12) && cmd_data_o[7];

    always_comb begin
        state_next = state;
        delay_load = '0;
        delay_set  = 1'b0;
        start_acc  = 1'b0;
        fetch_en   = 1'b0;
        retry_inc  = 1'b0;
        ack_done   = 1'b0;
        abort      = 1'b0;
        index_inc  = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_next = ST_PWRUP;
                    delay_load = PWRUP_LOAD;
                    delay_set  = 1'b1;
                    start_acc  = 1'b1;
                end
            end
            ST_PWRUP: begin
                if (delay_expired) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fetch_en = 1'b1;
                if (is_terminator) begin
                    state_next = ST_DONE;
                    finish     = 1'b1;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_done_i) begin
                    if (cmd_nack_i) begin
                        if (retry_cnt < MAX_RETRY_CNT) begin
                            state_next = ST_GAP;
                            delay_load = GAP_LOAD;
                            delay_set  = 1'b1;
                            retry_inc  = 1'b1;
                        end else begin
                            state_next = ST_ERROR;
                            abort      = 1'b1;
                        end
                    end else begin
                        ack_done  = 1'b1;
                        delay_set = 1'b1;
                        if (is_soft_reset) begin
                            state_next = ST_SETTLE;
                            delay_load = SETTLE_LOAD;
                        end else begin
                            state_next = ST_GAP;
                            delay_load = GAP_LOAD;
                        end
                    end
                end
            end
            ST_SETTLE, ST_GAP: begin
                if (delay_expired) begin
                    if (retrying) begin
                        state_next = ST_ISSUE;
                    end else if (index_o == LAST_INDEX) begin
                        state_next = ST_DONE;
                        finish     = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                        index_inc  = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            delay_cnt   <= '0;
            retry_cnt   <= '0;
            retrying    <= 1'b0;
            index_o     <= '0;
            cmd_valid_o <= 1'b0;
            cmd_addr_o  <= '0;
            cmd_data_o  <= '0;
            cmd_rw_o    <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_addr_o   <= '0;
            rd_data_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            err_index_o <= '0;
        end else begin
            state       <= state_next;
            cmd_valid_o <= (state_next == ST_ISSUE);
            rd_valid_o  <= 1'b0;

            if (delay_set) begin
                delay_cnt <= delay_load;
            end else if ((state == ST_PWRUP || state == ST_SETTLE || state == ST_GAP) &&
                         delay_cnt != '0) begin
                delay_cnt <= delay_cnt - 24'd1;
            end

            if (start_acc) begin
                index_o   <= '0;
                done_o    <= 1'b0;
                error_o   <= 1'b0;
                busy_o    <= 1'b1;
                retry_cnt <= '0;
                retrying  <= 1'b0;
            end

            if (fetch_en) begin
                cmd_addr_o <= data_i[16:9];
                cmd_data_o <= data_i[8:1];
                cmd_rw_o   <= data_i[0];
                retry_cnt  <= '0;
                retrying   <= 1'b0;
            end

            if (retry_inc) begin
                retry_cnt <= retry_cnt + 8'd1;
                retrying  <= 1'b1;
            end

            if (ack_done) begin
                retrying <= 1'b0;
                if (!cmd_rw_o) begin
                    rd_valid_o <= 1'b1;
                    rd_addr_o  <= cmd_addr_o;
                    rd_data_o  <= cmd_rdata_i;
                end
            end

            if (abort) begin
                err_index_o <= index_o;
                error_o     <= 1'b1;
                busy_o      <= 1'b0;
            end

            if (index_inc) begin
                index_o <= index_o + 7'd1;
            end

            if (finish) begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
            end
        end
    end

endmodule
